histogram_readout_sequencer: RTL and testbench

Drives the counter querying interface of the streaming histogram to read out a contiguous range of bins. Each returned count is emitted, in bin order, on a valid/ready dump stream toward the host/DMA path. The histogram query pipeline cannot be stalled, so the block issues queries only against free buffer credits. This guarantees that no returned count is ever dropped under downstream backpressure.

---
 rtl/histogram_readout_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_histogram_readout_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_readout_sequencer.sv
// histogram_readout_sequencer
//
// Reads a contiguous, possibly wrapping, range of bins out of the streaming
// histogram. Each bin is queried once, its returned count travels into a small
// return buffer, and the buffer head is offered on a valid/ready dump stream.
// The query pipeline cannot be stalled. A query is therefore issued only while
// the in-flight queries plus the buffered entries leave a free buffer slot.
// This ensures that no returned count is ever dropped.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle readout request (only honoured when idle)
//   start_word        first bin of the range, latched on an accepted start
//   end_word          last bin of the range (inclusive), latched on start
//   busy              high from accepted start until done
//   done              one-cycle pulse after the final beat is accepted
//   query_valid       query strobe to the histogram
//   query_word        bin being queried
//   query_count       count returned query_latency cycles after a query
//   dump_valid        dump beat valid (return buffer non-empty)
//   dump_ready        downstream accepts the beat when valid & ready
//   dump_word         bin index of the beat
//   dump_count        count of that bin
//   dump_last         high on the beat for end_word
//   dbg_state         current FSM state (debug visibility)
//
// Dump handshake: a beat transfers on a rising edge where dump_valid and
// dump_ready are both high. While dump_valid is high and dump_ready is low,
// dump_valid and all beat fields hold stable. dump_valid never depends on
// dump_ready.

module histogram_readout_sequencer #(
    parameter int word_width    = 12,
    parameter int count_width   = 48,
    parameter int query_latency = 2,
    parameter int fifo_depth    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [word_width-1:0]  start_word,
    input  logic [word_width-1:0]  end_word,
    output logic                   busy,
    output logic                   done,
    output logic                   query_valid,
    output logic [word_width-1:0]  query_word,
    input  logic [count_width-1:0] query_count,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [word_width-1:0]  dump_word,
    output logic [count_width-1:0] dump_count,
    output logic                   dump_last,
    output logic [1:0]             dbg_state
);

    localparam int cnt_w = $clog2(fifo_depth + 1);
    localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam logic [cnt_w:0]   credit_limit  = (cnt_w + 1)'(fifo_depth);
    localparam logic [cnt_w-1:0] fifo_full_cnt = cnt_w'(fifo_depth);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_issue = 2'd1;
    localparam logic [1:0] st_drain = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic [word_width-1:0] word;
        logic                  last;
    } tag_t;

    typedef struct packed {
        logic [word_width-1:0]  word;
        logic [count_width-1:0] count;
        logic                   last;
    } entry_t;

    logic [1:0]            state_q, state_d;
    logic [word_width-1:0] next_word_q, next_word_d;
    logic [word_width:0]   remaining_q, remaining_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    tag_t                  tag_q [query_latency];
    tag_t                  tag_d [query_latency];
    logic [cnt_w-1:0]      inflight_q, inflight_d;
    entry_t                mem_q [fifo_depth];
    entry_t                mem_d [fifo_depth];
    logic [ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0]      fifo_count_q, fifo_count_d;

    logic   credit_ok;
    logic   issue;
    logic   issue_last;
    logic   push;
    logic   pop;
    entry_t head;

    // Registered counts make the credit check conservative by one pop. With
    // query_latency+1 < fifo_depth the steady state (latency queries in
    // flight plus one buffered beat) still issues every cycle.
    assign credit_ok  = ({1'b0, inflight_q} + {1'b0, fifo_count_q}) < credit_limit;
    assign issue      = (state_q == st_issue) && credit_ok;
    assign issue_last = (remaining_q == (word_width + 1)'(1));
    assign push       = tag_q[query_latency-1].valid;
    assign head       = mem_q[rd_ptr_q];
    assign pop        = (fifo_count_q != '0) && dump_ready;

    // Sequencing FSM
    always_comb begin
        state_d     = state_q;
        next_word_d = next_word_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            st_idle: begin
                if (start) begin
                    next_word_d = start_word;
                    // Modular difference handles ranges that wrap through the top bin.
                    remaining_d = {1'b0, end_word - start_word} + (word_width + 1)'(1);
                    busy_d      = 1'b1;
                    state_d     = st_issue;
                end
            end
            st_issue: begin
                if (issue) begin
                    next_word_d = next_word_q + word_width'(1);
                    remaining_d = remaining_q - (word_width + 1)'(1);
                    if (issue_last) begin
                        state_d = st_drain;
                    end
                end
            end
            st_drain: begin
                if (pop && head.last) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = st_idle;
                end
            end
            default: state_d = st_idle;
        endcase
    end

    // Tag pipeline, return buffer and credit counters
    always_comb begin
        tag_d[0].valid = issue;
        tag_d[0].word  = next_word_q;
        tag_d[0].last  = issue && issue_last;
        for (int i = 1; i < query_latency; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            // The tail tag lines up with the count for the same query.
            mem_d[wr_ptr_q].word  = tag_q[query_latency-1].word;
            mem_d[wr_ptr_q].count = query_count;
            mem_d[wr_ptr_q].last  = tag_q[query_latency-1].last;
            wr_ptr_d              = wr_ptr_q + ptr_w'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_w'(1);
        end

        fifo_count_d = fifo_count_q;
        unique case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + cnt_w'(1);
            2'b01:   fifo_count_d = fifo_count_q - cnt_w'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        inflight_d = inflight_q;
        unique case ({issue, push})
            2'b10:   inflight_d = inflight_q + cnt_w'(1);
            2'b01:   inflight_d = inflight_q - cnt_w'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= st_idle;
            next_word_q  <= '0;
            remaining_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tag_q        <= '{default: '0};
            inflight_q   <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            next_word_q  <= next_word_d;
            remaining_q  <= remaining_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tag_q        <= tag_d;
            inflight_q   <= inflight_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // A push into a full buffer without a simultaneous pop would lose a count.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_count_q == fifo_full_cnt)));

    assign busy        = busy_q;
    assign done        = done_q;
    assign query_valid = issue;
    assign query_word  = issue ? next_word_q : '0;
    assign dump_valid  = (fifo_count_q != '0);
    assign dump_word   = dump_valid ? head.word  : '0;
    assign dump_count  = dump_valid ? head.count : '0;
    assign dump_last   = dump_valid ? head.last  : 1'b0;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_histogram_readout_sequencer.sv
module tb_histogram_readout_sequencer;

    localparam int WW = 12;
    localparam int CW = 48;
    localparam int QL = 2;
    localparam int FD = 4;
    localparam int EW = WW + CW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [WW-1:0] start_word;
    logic [WW-1:0] end_word;
    logic          busy;
    logic          done;
    logic          query_valid;
    logic [WW-1:0] query_word;
    logic [CW-1:0] query_count;
    logic          dump_valid;
    logic          dump_ready;
    logic [WW-1:0] dump_word;
    logic [CW-1:0] dump_count;
    logic          dump_last;
    logic [1:0]    dbg_state;

    histogram_readout_sequencer #(
        .word_width(WW), .count_width(CW), .query_latency(QL), .fifo_depth(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_word(start_word),
        .end_word(end_word), .busy(busy), .done(done),
        .query_valid(query_valid), .query_word(query_word),
        .query_count(query_count), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_word(dump_word),
        .dump_count(dump_count), .dump_last(dump_last), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- histogram stub: count = bin*3 + salt, latency 2 ----------------
    logic [CW-1:0] salt_v = '0;
    logic [CW-1:0] stub_s1, stub_s2;
    always @(posedge clk) begin
        stub_s1 <= query_valid ? (CW'(query_word) * CW'(3) + salt_v) : CW'(48'hDEAD_BEEF_0000);
        stub_s2 <= stub_s1;
    end
    assign query_count = stub_s2;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt, done_cyc, run_beats, out_issued, out_beats;
    int ready_mode = 0;
    int run_start_cyc = 0;
    bit prev_hold;
    logic [EW-1:0] prev_data;
    logic [EW-1:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: beats for a range, computed from the range rule.
    task automatic model_fill(input logic [WW-1:0] s, input logic [WW-1:0] e, input logic [CW-1:0] salt);
        int n;
        int w;
        n = ((int'(e) - int'(s) + (1 << WW)) % (1 << WW)) + 1;
        for (int i = 0; i < n; i++) begin
            w = (int'(s) + i) % (1 << WW);
            exp_q.push_back({WW'(w), CW'(w) * CW'(3) + salt, (i == n - 1)});
        end
    endtask

    // ---------------- dump_ready driver ----------------
    initial begin
        dump_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: dump_ready = 1'b1;
                1: dump_ready = (cyc % 2) == 1;
                2: dump_ready = 1'($urandom_range(0, 1));
                default: dump_ready = !((cyc - run_start_cyc) >= 4 && (cyc - run_start_cyc) < 14);
            endcase
        end
    end

    // ---------------- monitor (samples on the falling edge) ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_hold  = 1'b0;
            out_issued = 0;
            out_beats  = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(dump_valid), 64'd1);
                check("hold_data", 64'({dump_word, dump_count, dump_last}), 64'(prev_data));
            end
            if (dump_valid && dump_ready) begin
                run_beats++;
                out_beats++;
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("beat_word", 64'(dump_word), 64'(mon_e[EW-1 -: WW]));
                    check("beat_count", 64'(dump_count), 64'(mon_e[CW:1]));
                    check("beat_last", 64'(dump_last), 64'(mon_e[0]));
                end
            end
            if (query_valid) begin
                out_issued++;
                check("outstanding_le_depth", 64'((out_issued - out_beats) <= FD), 64'd1);
            end
            prev_hold = dump_valid && !dump_ready;
            prev_data = {dump_word, dump_count, dump_last};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_all_beats_seen", 64'(exp_q.size()), 64'd0);
                check("done_busy_low", 64'(busy), 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_readout(input logic [WW-1:0] s, input logic [WW-1:0] e, input int mode,
                               input bit inject, input int exp_n, input logic [CW-1:0] salt);
        int t;
        int budget;
        int st_cyc;
        salt_v     = salt;
        model_fill(s, e, salt);
        done_cnt   = 0;
        run_beats  = 0;
        @(posedge clk);
        #1;
        ready_mode    = mode;
        run_start_cyc = cyc;
        st_cyc        = cyc;
        start_word    = s;
        end_word      = e;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_word = WW'($urandom);
        end_word   = WW'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        if (inject) begin
            repeat (2) @(posedge clk);
            #1;
            start      = 1'b1;
            start_word = s + WW'(100);
            end_word   = s + WW'(3);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        budget = 3 * exp_n + 100;
        t = 0;
        while (done_cnt == 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        check("done_within_budget", 64'(done_cnt != 0), 64'd1);
        if (mode == 0 && done_cnt != 0) begin
            check("done_latency", 64'(done_cyc - st_cyc), 64'(exp_n + QL + 2));
        end
        repeat (5) @(posedge clk);
        #1;
        check("single_done", 64'(done_cnt), 64'd1);
        check("beat_total", 64'(run_beats), 64'(exp_n));
        check("busy_low_after", 64'(busy), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [WW-1:0] s;
        logic [WW-1:0] e;
        int            mode;
        bit            inject;
        int            exp_n;
        logic [CW-1:0] salt;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{12'd5,    12'd9,    0, 1'b0, 5,    48'd0};  // basic
        tbl[1] = '{12'd4094, 12'd1,    0, 1'b0, 4,    48'd0};  // wrap
        tbl[2] = '{12'd7,    12'd7,    0, 1'b0, 1,    48'd100}; // single bin
        tbl[3] = '{12'd20,   12'd35,   3, 1'b0, 16,   48'd7};  // 10-cycle stall
        tbl[4] = '{12'd300,  12'd311,  0, 1'b1, 12,   48'd5};  // start while busy
        tbl[5] = '{12'd0,    12'd4095, 1, 1'b0, 4096, 48'd9};  // full range, toggling ready
        tbl[6] = '{12'd4095, 12'd0,    2, 1'b0, 2,    48'd1};  // wrap at top, random ready

        rst        = 1'b1;
        start      = 1'b0;
        start_word = '0;
        end_word   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_query_valid", 64'(query_valid), 64'd0);
        check("rst_query_word", 64'(query_word), 64'd0);
        check("rst_dump_valid", 64'(dump_valid), 64'd0);
        check("rst_dump_word", 64'(dump_word), 64'd0);
        check("rst_dump_count", 64'(dump_count), 64'd0);
        check("rst_dump_last", 64'(dump_last), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_readout(tbl[i].s, tbl[i].e, tbl[i].mode, tbl[i].inject, tbl[i].exp_n, tbl[i].salt);
        end

        // Reset three cycles into a 16-bin readout: silent abort.
        salt_v = 48'd11;
        model_fill(12'd100, 12'd115, 48'd11);
        ready_mode = 0;
        @(posedge clk);
        #1;
        start_word = 12'd100;
        end_word   = 12'd115;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        done_cnt  = 0;
        run_beats = 0;
        @(negedge clk);
        check("abort_dump_valid", 64'(dump_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_query_valid", 64'(query_valid), 64'd0);
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_no_beats", 64'(run_beats), 64'd0);
        run_readout(12'd200, 12'd203, 0, 1'b0, 4, 48'd13);

        // Randomized ranges and backpressure against the reference model.
        for (int k = 0; k < 8; k++) begin
            logic [WW-1:0] rs;
            int            len;
            rs  = WW'($urandom_range(0, (1 << WW) - 1));
            len = $urandom_range(1, 40);
            run_readout(rs, rs + WW'(len - 1), $urandom_range(0, 2), 1'b0, len, CW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
